bus_arbiter: RTL and testbench

- Sits directly downstream of the traffic-generating clients and upstream of the single memory server.
- Collects NUM_CLIENTS request/address/data bundles and grants one client at a time using round-robin.
- Forwards the granted transaction to the server, waits for completion, then returns a one-cycle ack and the read data to the granted client.

---
 rtl/bus_arbiter_pkg.sv | 14 +
 rtl/bus_arbiter_if.sv | 34 +++
 rtl/bus_arbiter_rr_priority_picker.sv | 30 +++
 rtl/bus_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and default sizes for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  localparam int DATA_WIDTH_DEF     = 8;
  localparam int ADDR_WIDTH_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/bus_arbiter_if.sv
// Client and server bundle of the bus arbiter; slave is the arbiter's view.
interface bus_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
);

  logic [NUM_CLIENTS-1:0]            rq;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] address;
  logic [NUM_CLIENTS-1:0]            wr_ni;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] dataW;
  logic [NUM_CLIENTS-1:0]            ack;
  logic [DATA_WIDTH-1:0]             dataR;

  logic                              srv_valid;
  logic [ADDR_WIDTH-1:0]             srv_address;
  logic                              srv_wr_ni;
  logic [DATA_WIDTH-1:0]             srv_dataW;
  logic                              srv_ready;
  logic [DATA_WIDTH-1:0]             srv_dataR;

  modport master (
    output rq, address, wr_ni, dataW, srv_ready, srv_dataR,
    input  ack, dataR, srv_valid, srv_address, srv_wr_ni, srv_dataW
  );

  modport slave (
    input  rq, address, wr_ni, dataW, srv_ready, srv_dataR,
    output ack, dataR, srv_valid, srv_address, srv_wr_ni, srv_dataW
  );

endinterface

// File: rtl/bus_arbiter_rr_priority_picker.sv
// Combinational round-robin search: first set req bit at or above ptr, wrapping.
module rr_priority_picker #(
  parameter int NUM_CLIENTS = 4
) (
  input  logic [NUM_CLIENTS-1:0]         req,
  input  logic [$clog2(NUM_CLIENTS)-1:0] ptr,
  output logic                           found,
  output logic [$clog2(NUM_CLIENTS)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  int cand;

  // Scan from the farthest candidate back to ptr so the closest one wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
      if (req[IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between NUM_CLIENTS clients and one memory server.
// Define ARB_TIMEOUT_EN to add the server timeout and the err output.
//
// state | meaning
// IDLE  | waiting for a request; grants the next client round-robin
// BUSY  | granted transaction presented to the server
// ACK   | one-cycle ack to the granted client; rr pointer advances
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
`ifdef ARB_TIMEOUT_EN
  ,
  output logic          err
`endif
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_flag;

  assign err = (state == ACK) && tmo_flag;
`endif

  rr_priority_picker #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_picker (
    .req   (bus.rq),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt     = state;
    bus.ack       = '0;
    bus.srv_valid = 1'b0;
    unique case (state)
      IDLE: if (pick_found) state_nxt = BUSY;
      BUSY: begin
        bus.srv_valid = 1'b1;
        if (bus.srv_ready) state_nxt = ACK;
`ifdef ARB_TIMEOUT_EN
        else if (tmo_cnt == '0) state_nxt = ACK;
`endif
      end
      ACK: begin
        bus.ack[grant] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      grant           <= '0;
      rr_ptr          <= '0;
      bus.dataR       <= '0;
      bus.srv_address <= '0;
      bus.srv_wr_ni   <= 1'b0;
      bus.srv_dataW   <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt         <= '0;
      tmo_flag        <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant           <= pick_idx;
            bus.srv_address <= bus.address[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.srv_wr_ni   <= bus.wr_ni[pick_idx];
            bus.srv_dataW   <= bus.dataW[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
`ifdef ARB_TIMEOUT_EN
            tmo_cnt         <= TMO_W'(TIMEOUT_CYCLES - 1);
            tmo_flag        <= 1'b0;
`endif
          end
        end
        BUSY: begin
          // Writes also load dataR; the server's read bus is passed through as-is.
          if (bus.srv_ready) bus.dataR <= bus.srv_dataR;
`ifdef ARB_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            bus.dataR <= '0;
            tmo_flag  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        ACK: begin
          rr_ptr <= (grant == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin model.
module tb_bus_arbiter;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TMO = 16;

  logic clk;
  logic reset;
`ifdef ARB_TIMEOUT_EN
  logic err;
`endif

  bus_arbiter_if #(.NUM_CLIENTS(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bus_arbiter #(
    .NUM_CLIENTS (NC),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW)
`ifdef ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TMO)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_TIMEOUT_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // client-side model state
  logic [NC-1:0] pend;
  logic [AW-1:0] c_addr [NC];
  logic          c_wr   [NC];
  logic [DW-1:0] c_dw   [NC];
  int            ptr_m;
  logic [DW-1:0] dataR_m;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_model(input logic [NC-1:0] req, input int ptr);
    for (int k = 0; k < NC; k++) begin
      if (req[(ptr + k) % NC]) return (ptr + k) % NC;
    end
    return -1;
  endfunction

  task automatic drive_clients();
    bus.rq = pend;
    for (int i = 0; i < NC; i++) begin
      bus.address[i*AW +: AW] = c_addr[i];
      bus.wr_ni[i]            = c_wr[i];
      bus.dataW[i*DW +: DW]   = c_dw[i];
    end
  endtask

  task automatic new_request(input int i);
    pend[i]   = 1'b1;
    c_addr[i] = AW'($urandom);
    c_wr[i]   = 1'($urandom);
    c_dw[i]   = DW'($urandom);
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_ack"}, 32'(bus.ack), 32'd0);
    check_val({tag, "_valid"}, 32'(bus.srv_valid), 32'd0);
    check_val({tag, "_dataR"}, 32'(bus.dataR), 32'(dataR_m));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend  = '0;
    drive_clients();
    bus.srv_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ptr_m   = 0;
    dataR_m = '0;
    check_quiet("rst");
    check_val("rst_addr", 32'(bus.srv_address), 32'd0);
    check_val("rst_wr", 32'(bus.srv_wr_ni), 32'd0);
    check_val("rst_dw", 32'(bus.srv_dataW), 32'd0);
    reset = 1'b0;
  endtask

  // Called at a negedge in IDLE with pend != 0; returns at the negedge of the
  // mandatory IDLE cycle following the ack.
  task automatic txn(input int delay, input logic [DW-1:0] rdata, input bit scramble);
    int            exp;
    logic [AW-1:0] e_addr;
    logic          e_wr;
    logic [DW-1:0] e_dw;
    int            j;
    exp    = pick_model(pend, ptr_m);
    e_addr = c_addr[exp];
    e_wr   = c_wr[exp];
    e_dw   = c_dw[exp];
    drive_clients();
    bus.srv_ready = 1'($urandom);
    bus.srv_dataR = DW'($urandom);
    @(negedge clk);
    check_val("busy_valid", 32'(bus.srv_valid), 32'd1);
    check_val("busy_addr", 32'(bus.srv_address), 32'(e_addr));
    check_val("busy_wr", 32'(bus.srv_wr_ni), 32'(e_wr));
    check_val("busy_dw", 32'(bus.srv_dataW), 32'(e_dw));
    check_val("busy_ack", 32'(bus.ack), 32'd0);
    for (int n = 1; n <= delay; n++) begin
      bus.srv_ready = (n == delay);
      bus.srv_dataR = (n == delay) ? rdata : DW'($urandom);
      if (scramble) begin
        c_addr[exp] = c_addr[exp] ^ 4'hC;
        c_dw[exp]   = c_dw[exp] ^ 8'hFF;
        c_wr[exp]   = ~c_wr[exp];
        j = $urandom_range(0, NC - 1);
        if (!pend[j]) new_request(j);
        drive_clients();
      end
      @(negedge clk);
      if (n < delay) begin
        check_val("hold_valid", 32'(bus.srv_valid), 32'd1);
        check_val("hold_addr", 32'(bus.srv_address), 32'(e_addr));
        check_val("hold_dw", 32'(bus.srv_dataW), 32'(e_dw));
        check_val("hold_ack", 32'(bus.ack), 32'd0);
      end
    end
    dataR_m = rdata;
    check_val("ack_onehot", 32'(bus.ack), 32'd1 << exp);
    check_val("ack_valid", 32'(bus.srv_valid), 32'd0);
    check_val("ack_dataR", 32'(bus.dataR), 32'(dataR_m));
`ifdef ARB_TIMEOUT_EN
    check_val("ack_err", 32'(err), 32'd0);
`endif
    pend[exp] = 1'b0;
    ptr_m     = (exp + 1) % NC;
    drive_clients();
    bus.srv_ready = 1'($urandom);
    bus.srv_dataR = DW'($urandom);
    @(negedge clk);
    check_quiet("post_ack");
    bus.srv_ready = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    pend          = '0;
    bus.srv_ready = 1'b0;
    bus.srv_dataR = '0;
    for (int i = 0; i < NC; i++) begin
      c_addr[i] = '0;
      c_wr[i]   = 1'b0;
      c_dw[i]   = '0;
    end
    drive_clients();
    do_reset();

    // single read from client 0, ready on the 2nd BUSY cycle
    pend      = 4'b0001;
    c_addr[0] = 4'd3;
    c_wr[0]   = 1'b1;
    c_dw[0]   = 8'h11;
    txn(2, 8'hA5, 1'b0);

    // all four requesting: served 0,1,2,3
    do_reset();
    for (int i = 0; i < NC; i++) new_request(i);
    for (int i = 0; i < NC; i++) txn($urandom_range(1, 4), DW'($urandom), 1'b0);

    // client 2 writing repeatedly
    for (int r = 0; r < 3; r++) begin
      pend      = 4'b0100;
      c_addr[2] = AW'(r + 1);
      c_wr[2]   = 1'b0;
      c_dw[2]   = 8'h3C;
      txn($urandom_range(1, 3), DW'($urandom), 1'b0);
    end

    // client 1 address changes 5 -> 9 while BUSY
    pend      = 4'b0010;
    c_addr[1] = 4'd5;
    c_wr[1]   = 1'b1;
    c_dw[1]   = 8'h00;
    txn(3, 8'h5A, 1'b1);
    pend = '0;

    // reset while BUSY aborts, pointer returns to 0
    pend      = 4'b0010;
    c_addr[1] = 4'd7;
    drive_clients();
    @(negedge clk);
    check_val("pre_abort_valid", 32'(bus.srv_valid), 32'd1);
    reset = 1'b1;
    pend  = '0;
    drive_clients();
    @(negedge clk);
    ptr_m   = 0;
    dataR_m = '0;
    check_quiet("abort");
    reset = 1'b0;
    pend  = 4'b1010;
    txn(1, 8'hC3, 1'b0);
    pend      = 4'b0100;
    c_dw[2]   = 8'h3C;
    txn(1, 8'h96, 1'b0);
    pend = '0;

    // randomized traffic
    do_reset();
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < NC; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) new_request(i);
      end
      if (pend == '0) begin
        drive_clients();
        bus.srv_ready = 1'($urandom);
        bus.srv_dataR = DW'($urandom);
        @(negedge clk);
        check_quiet("idle");
        bus.srv_ready = 1'b0;
      end else begin
        txn($urandom_range(1, 5), DW'($urandom), 1'($urandom));
      end
    end

`ifdef ARB_TIMEOUT_EN
    // server never answers: forced ack after TMO BUSY cycles
    do_reset();
    pend      = 4'b0001;
    c_addr[0] = 4'd2;
    drive_clients();
    bus.srv_ready = 1'b0;
    @(negedge clk);
    for (int n = 1; n < TMO; n++) begin
      check_val("tmo_valid", 32'(bus.srv_valid), 32'd1);
      check_val("tmo_err_early", 32'(err), 32'd0);
      @(negedge clk);
    end
    check_val("tmo_last_valid", 32'(bus.srv_valid), 32'd1);
    @(negedge clk);
    check_val("tmo_ack", 32'(bus.ack), 32'd1);
    check_val("tmo_err", 32'(err), 32'd1);
    check_val("tmo_dataR", 32'(bus.dataR), 32'd0);
    pend = '0;
    drive_clients();
    @(negedge clk);
    check_val("tmo_err_clr", 32'(err), 32'd0);
    check_val("tmo_ack_clr", 32'(bus.ack), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
